// File: rtl/mixer_pkg.sv
// Shared constants, FSM state type and accumulator sizing for band_mixer.
// Optional macro BAND_MIXER_ROUND_EN adds a rounding guard bit to the accumulator.
package mixer_pkg;

    localparam int unsigned MIX_DATA_W    = 24;
    localparam int unsigned MIX_GAIN_W    = 8;
    localparam int unsigned MIX_GAIN_FRAC = 6;

`ifdef BAND_MIXER_ROUND_EN
    // Headroom for the half-LSB rounding bias.
    localparam int unsigned MIX_GUARD_W = 1;
`else
    localparam int unsigned MIX_GUARD_W = 0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } mix_state_e;

    // Product width plus enough growth to sum every band without wrapping.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned gain_w,
                                              input int unsigned bands);
        return data_w + gain_w + 1 + $clog2(bands) + MIX_GUARD_W;
    endfunction

endpackage

// File: rtl/mixer_sat.sv
// Combinational shift / optional round / clamp of the MAC accumulator.
// With BAND_MIXER_ROUND_EN defined, half an output LSB is added before the shift.
module mixer_sat
    import mixer_pkg::*;
#(
    parameter int unsigned ACC_W     = 35,
    parameter int unsigned DATA_W    = MIX_DATA_W,
    parameter int unsigned GAIN_FRAC = MIX_GAIN_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] data_o,
    output logic                     clip_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef BAND_MIXER_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_BIAS =
        (GAIN_FRAC > 0) ? (ACC_W'(1) << ((GAIN_FRAC > 0) ? GAIN_FRAC - 1 : 0)) : '0;
`else
    localparam logic signed [ACC_W-1:0] RND_BIAS = '0;
`endif

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    // Bias, arithmetic shift (floor), then clamp to the signed output range.
    always_comb begin
        biased  = acc_i + RND_BIAS;
        shifted = biased >>> GAIN_FRAC;
        clip_o  = 1'b0;
        data_o  = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            data_o = SAT_MAX[DATA_W-1:0];
            clip_o = 1'b1;
        end else if (shifted < SAT_MIN) begin
            data_o = SAT_MIN[DATA_W-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/band_mixer.sv
// N-band gain-and-sum stage: captures a frame, runs a shared-multiplier MAC over
// the bands, then emits one saturated sample with a one-cycle valid pulse.
// Optional macro BAND_MIXER_ROUND_EN selects round-half-up instead of truncation.
module band_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned BANDS     = 4,
    parameter int unsigned DATA_W    = MIX_DATA_W,
    parameter int unsigned GAIN_W    = MIX_GAIN_W,
    parameter int unsigned GAIN_FRAC = MIX_GAIN_FRAC
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [BANDS*DATA_W-1:0] data_i,
    input  logic [BANDS*GAIN_W-1:0] gain_i,
    input  logic                    ena_i,
    input  logic                    clr_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    ena_o,
    output logic                    clip_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int unsigned ACC_W  = acc_width(DATA_W, GAIN_W, BANDS);
    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
    localparam int unsigned IDX_W  = (BANDS > 1) ? $clog2(BANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANDS - 1);

    mix_state_e state_q, state_d;

    logic [DATA_W-1:0] sample_q [BANDS];
    logic [GAIN_W-1:0] gain_q   [BANDS];

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]       cur_sample;
    logic [GAIN_W-1:0]       cur_gain;
    logic                    capture;
    logic                    ovr_set;

    logic [DATA_W-1:0] sat_data;
    logic              sat_clip;

    logic [DATA_W-1:0] data_q;
    logic              ena_q;
    logic              clip_q;
    logic              busy_q;
    logic              overrun_q;

    // Shared multiplier: signed sample times zero-extended gain.
    always_comb begin
        cur_sample = sample_q[idx_q];
        cur_gain   = gain_q[idx_q];
        prod = $signed({{(GAIN_W+1){cur_sample[DATA_W-1]}}, cur_sample})
             * $signed({{(DATA_W+1){1'b0}}, cur_gain});
    end

    // FSM next state, MAC accumulate and band index sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ena_i) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A strobe that lands while a frame is in flight is dropped and flagged.
    assign ovr_set = ena_i && (state_q != IDLE);

    mixer_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_sat (
        .acc_i  (acc_q),
        .data_o (sat_data),
        .clip_o (sat_clip)
    );

    // Frame capture: samples and gains are frozen for the whole MAC pass.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(BANDS); k++) begin
                sample_q[k] <= '0;
                gain_q[k]   <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < int'(BANDS); k++) begin
                sample_q[k] <= data_i[k*DATA_W +: DATA_W];
                gain_q[k]   <= gain_i[k*GAIN_W +: GAIN_W];
            end
        end
    end

    // FSM, accumulator, index and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            ena_q     <= 1'b0;
            clip_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            busy_q    <= (state_d != IDLE);
            ena_q     <= (state_q == OUT);
            clip_q    <= (state_q == OUT) && sat_clip;
            // Set has priority over clear.
            overrun_q <= ovr_set | (overrun_q & ~clr_i);
            if (state_q == OUT) begin
                data_q <= sat_data;
            end
        end
    end

    assign data_o    = data_q;
    assign ena_o     = ena_q;
    assign clip_o    = clip_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_band_mixer.sv
// Directed self-checking bench for band_mixer (defaults: 4 bands, 24-bit data,
// 8-bit gain, 6 fractional bits) plus a direct check of mixer_sat.
module tb_band_mixer;
    import mixer_pkg::*;

    localparam int unsigned BANDS = 4;
    localparam int unsigned DW    = 24;
    localparam int unsigned GW    = 8;
    localparam int unsigned SAT_ACC_W = acc_width(DW, GW, BANDS);

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic [BANDS*DW-1:0]   data_i = '0;
    logic [BANDS*GW-1:0]   gain_i = '0;
    logic                  ena_i = 1'b0;
    logic                  clr_i = 1'b0;
    logic [DW-1:0]         data_o;
    logic                  ena_o;
    logic                  clip_o;
    logic                  busy_o;
    logic                  overrun_o;

    logic signed [SAT_ACC_W-1:0] sat_acc = '0;
    logic [DW-1:0]               sat_data;
    logic                        sat_clip;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    band_mixer #(
        .BANDS     (BANDS),
        .DATA_W    (DW),
        .GAIN_W    (GW),
        .GAIN_FRAC (6)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .gain_i    (gain_i),
        .ena_i     (ena_i),
        .clr_i     (clr_i),
        .data_o    (data_o),
        .ena_o     (ena_o),
        .clip_o    (clip_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    mixer_sat #(
        .ACC_W     (SAT_ACC_W),
        .DATA_W    (DW),
        .GAIN_FRAC (6)
    ) u_sat_ut (
        .acc_i  (sat_acc),
        .data_o (sat_data),
        .clip_o (sat_clip)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BANDS*DW-1:0] pack4(input int a, input int b, input int c,
                                                  input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Reference: full-precision sum, optional half-LSB bias, floor shift, clamp.
    function automatic logic [DW:0] model(input logic [BANDS*DW-1:0] d,
                                          input logic [BANDS*GW-1:0] g);
        longint acc;
        longint sh;
        logic [DW-1:0] lo;
        acc = 0;
        for (int k = 0; k < int'(BANDS); k++) begin
            acc += longint'($signed(d[k*DW +: DW])) * longint'(g[k*GW +: GW]);
        end
`ifdef BAND_MIXER_ROUND_EN
        acc += 32;
`endif
        sh = acc >>> 6;
        if (sh > 64'sd8388607) return {1'b1, 24'h7FFFFF};
        if (sh < -64'sd8388608) return {1'b1, 24'h800000};
        lo = sh[DW-1:0];
        return {1'b0, lo};
    endfunction

    // Launch one frame and wait (bounded) for its result.
    // disturb: 1 = change inputs right after capture, 2 = extra ena_i, 3 = ena_i with clr_i.
    task automatic frame(input logic [BANDS*DW-1:0] d, input logic [BANDS*GW-1:0] g,
                         input int disturb, output logic [DW-1:0] res, output logic clp,
                         output int lat, output int busy_n);
        data_i = d;
        gain_i = g;
        ena_i  = 1'b1;
        tick();
        ena_i  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (ena_o !== 1'b1 && lat < 20) begin
            if (busy_o === 1'b1) busy_n++;
            if (disturb == 1 && lat == 0) begin
                gain_i = '0;
                data_i = pack4(999, 999, 999, 999);
            end
            if (disturb == 2 && lat == 1) begin
                ena_i  = 1'b1;
                data_i = pack4(5000, 5000, 5000, 5000);
            end
            if (disturb == 3 && lat == 1) begin
                ena_i = 1'b1;
                clr_i = 1'b1;
            end
            if (lat == 2) begin
                ena_i = 1'b0;
                clr_i = 1'b0;
            end
            tick();
            lat++;
        end
        res = data_o;
        clp = clip_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] res;
        logic          clp;
        int            lat;
        int            busy_n;
        int            extra;
        logic [DW:0]   exp;
        logic [BANDS*DW-1:0] rd;
        logic [BANDS*GW-1:0] rg;

        // Saturator unit checks.
        sat_acc = SAT_ACC_W'(64'sd257 * 64);
        #1;
        chk("sat_mid_data", 64'(sat_data), 64'd257);
        chk("sat_mid_clip", 64'(sat_clip), 64'd0);
        sat_acc = SAT_ACC_W'(64'sd8388607 * 64 + 63);
        #1;
        chk("sat_top_data", 64'(sat_data), 64'h7FFFFF);
`ifdef BAND_MIXER_ROUND_EN
        chk("sat_top_clip", 64'(sat_clip), 64'd1);
`else
        chk("sat_top_clip", 64'(sat_clip), 64'd0);
`endif
        sat_acc = SAT_ACC_W'(64'sd8388608 * 64);
        #1;
        chk("sat_pos_data", 64'(sat_data), 64'h7FFFFF);
        chk("sat_pos_clip", 64'(sat_clip), 64'd1);
        sat_acc = SAT_ACC_W'(-64'sd8388608 * 64);
        #1;
        chk("sat_min_data", 64'(sat_data), 64'h800000);
        chk("sat_min_clip", 64'(sat_clip), 64'd0);
        sat_acc = SAT_ACC_W'(-64'sd8388608 * 64 - 1);
        #1;
        chk("sat_below_data", 64'(sat_data), 64'h800000);
`ifdef BAND_MIXER_ROUND_EN
        chk("sat_below_clip", 64'(sat_clip), 64'd0);
`else
        chk("sat_below_clip", 64'(sat_clip), 64'd1);
`endif

        // Reset state.
        rst_i = 1'b1;
        tick();
        tick();
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_ena", 64'(ena_o), 64'd0);
        chk("rst_clip", 64'(clip_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ovr", 64'(overrun_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Unity gains.
        frame(pack4(100, 200, -50, 7), {4{8'h40}}, 0, res, clp, lat, busy_n);
        chk("unity_data", 64'(res), 64'd257);
        chk("unity_clip", 64'(clp), 64'd0);
        chk("unity_lat", 64'(lat), 64'd5);
        chk("unity_busy", 64'(busy_n), 64'd5);
        tick();
        chk("unity_ena_pulse", 64'(ena_o), 64'd0);
        chk("unity_hold", 64'(data_o), 64'd257);
        chk("unity_idle_busy", 64'(busy_o), 64'd0);

        // Positive and negative saturation.
        frame({4{24'h7FFFFF}}, {4{8'h40}}, 0, res, clp, lat, busy_n);
        chk("posclip_data", 64'(res), 64'h7FFFFF);
        chk("posclip_clip", 64'(clp), 64'd1);
        tick();
        chk("posclip_clip_low", 64'(clip_o), 64'd0);
        frame({4{24'h800000}}, {4{8'hFF}}, 0, res, clp, lat, busy_n);
        chk("negclip_data", 64'(res), 64'h800000);
        chk("negclip_clip", 64'(clp), 64'd1);

        // Rounding on band 0 with half gain.
        frame(pack4(3, 0, 0, 0), 32'h0000_0020, 0, res, clp, lat, busy_n);
`ifdef BAND_MIXER_ROUND_EN
        chk("round_pos", 64'(res), 64'd2);
`else
        chk("round_pos", 64'(res), 64'd1);
`endif
        frame(pack4(-3, 0, 0, 0), 32'h0000_0020, 0, res, clp, lat, busy_n);
`ifdef BAND_MIXER_ROUND_EN
        chk("round_neg", 64'(res), 64'hFFFFFF);
`else
        chk("round_neg", 64'(res), 64'hFFFFFE);
`endif
        chk("round_neg_clip", 64'(clp), 64'd0);

        // Inputs changed mid-frame do not disturb the captured frame.
        frame(pack4(100, 200, -50, 7), {4{8'h40}}, 1, res, clp, lat, busy_n);
        chk("capture_data", 64'(res), 64'd257);
        chk("capture_ovr", 64'(overrun_o), 64'd0);

        // Overrun: second strobe while busy is dropped and sticks until cleared.
        frame(pack4(100, 200, -50, 7), {4{8'h40}}, 2, res, clp, lat, busy_n);
        chk("ovr_data", 64'(res), 64'd257);
        chk("ovr_lat", 64'(lat), 64'd5);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ena_o === 1'b1) extra++;
        end
        chk("ovr_single_result", 64'(extra), 64'd0);
        chk("ovr_sticky", 64'(overrun_o), 64'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("ovr_cleared", 64'(overrun_o), 64'd0);

        // Set beats clear in the same cycle.
        frame(pack4(1, 2, 3, 4), {4{8'h40}}, 3, res, clp, lat, busy_n);
        chk("ovr_set_wins", 64'(overrun_o), 64'd1);
        chk("ovr_set_data", 64'(res), 64'd10);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;

        // Reset during MAC cycle 2 discards the frame.
        data_i = pack4(1000, 1000, 1000, 1000);
        gain_i = {4{8'h40}};
        ena_i  = 1'b1;
        tick();
        ena_i  = 1'b0;
        tick();
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_data", 64'(data_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ena", 64'(ena_o), 64'd0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ena_o === 1'b1) extra++;
        end
        chk("midrst_no_result", 64'(extra), 64'd0);
        frame(pack4(100, 200, -50, 7), {4{8'h40}}, 0, res, clp, lat, busy_n);
        chk("postrst_data", 64'(res), 64'd257);
        chk("postrst_lat", 64'(lat), 64'd5);

        // Back-to-back frames at full throughput.
        tick();
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < int'(BANDS); k++) begin
                rd[k*DW +: DW] = DW'($urandom);
                rg[k*GW +: GW] = GW'($urandom_range(0, 255));
            end
            if (f % 10 == 0) rd = {4{24'h7FF000}};
            exp = model(rd, rg);
            frame(rd, rg, 0, res, clp, lat, busy_n);
            chk("b2b_data", 64'(res), 64'(exp[DW-1:0]));
            chk("b2b_clip", 64'(clp), 64'(exp[DW]));
            chk("b2b_lat", 64'(lat), 64'd5);
        end
        chk("b2b_no_overrun", 64'(overrun_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
